// File: rtl/ibex_pkg.sv
// Shared writeback-path types and helpers for the register-file write arbiter.
package ibex_pkg;

  localparam int unsigned RegAddrW    = 5;
  localparam int unsigned RfDataWidth = 32;

  // One register-file write: destination plus data, at the default word width.
  typedef struct packed {
    logic [RegAddrW-1:0]    waddr;
    logic [RfDataWidth-1:0] wdata;
  } rf_wr_t;

  // RV32E only has x0..x15, so the top address bit is ignored.
  function automatic logic [RegAddrW-1:0] rf_addr_norm(input logic [RegAddrW-1:0] addr,
                                                       input bit                  rv32e);
    return rv32e ? {1'b0, addr[RegAddrW-2:0]} : addr;
  endfunction

endpackage

// File: rtl/ibex_rf_wb_fifo.sv
// Small circular FIFO used for the load-tag queue and the EX result buffer.
// Exposes occupancy, per-slot valid bits and the top TagWidth bits of each slot
// so the parent can match pending destinations without reading data it ignores.
// A push while full is accepted only when a pop happens in the same cycle;
// a pop while empty is ignored.
module ibex_rf_wb_fifo
  import ibex_pkg::*;
#(
  parameter  int unsigned Width    = 5,
  parameter  int unsigned TagWidth = 5,
  parameter  int unsigned Depth    = 2,
  localparam int unsigned CntW     = $clog2(Depth + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      push_i,
  input  logic [Width-1:0]          wdata_i,
  input  logic                      pop_i,
  output logic [Width-1:0]          rdata_o,
  output logic [CntW-1:0]           count_o,
  output logic [Depth-1:0]          valid_o,
  output logic [Depth*TagWidth-1:0] tags_o
);

  localparam int unsigned     PtrW    = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [Depth-1:0] valid_q, valid_d;
  logic             empty, full, do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(Depth));
  assign do_pop  = pop_i && !empty;
  assign do_push = push_i && (!full || do_pop);

  // Next pointers, occupancy and slot valid bits (clear on pop before set on push).
  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    valid_d = valid_q;
    count_d = count_q + CntW'(do_push) - CntW'(do_pop);
    if (do_pop) begin
      rptr_d           = (rptr_q == LastPtr) ? '0 : rptr_q + 1'b1;
      valid_d[rptr_q]  = 1'b0;
    end
    if (do_push) begin
      wptr_d           = (wptr_q == LastPtr) ? '0 : wptr_q + 1'b1;
      valid_d[wptr_q]  = 1'b1;
    end
  end

  // Control state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Storage; contents are meaningless unless the matching valid bit is set.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;
  assign valid_o = valid_q;

  for (genvar i = 0; i < Depth; i++) begin : g_tags
    assign tags_o[i*TagWidth +: TagWidth] = mem_q[i][Width-1 -: TagWidth];
  end

endmodule

// File: rtl/ibex_rf_write_arbiter.sv
// Writeback arbiter in front of the single register-file write port.
// Load responses always win; EX results that lose are buffered and drained in
// order. Pending destinations (load tags, buffered EX results, the write being
// presented this cycle) drive the RAW/WAW hazard flags for ID.
module ibex_rf_write_arbiter
  import ibex_pkg::*;
#(
  parameter int unsigned DataWidth  = 32,
  parameter bit          RV32E      = 1'b0,
  parameter int unsigned ExBufDepth = 2,
  parameter int unsigned MaxLoads   = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 ex_valid_i,
  output logic                 ex_ready_o,
  input  logic [4:0]           ex_waddr_i,
  input  logic [DataWidth-1:0] ex_wdata_i,
  input  logic                 load_issue_i,
  input  logic [4:0]           load_waddr_i,
  input  logic                 load_rvalid_i,
  input  logic [DataWidth-1:0] load_rdata_i,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  output logic                 rf_we_o,
  input  logic [4:0]           raddr_a_i,
  input  logic [4:0]           raddr_b_i,
  output logic                 hazard_a_o,
  output logic                 hazard_b_o,
  output logic                 waw_hazard_o,
  output logic                 loads_full_o,
  output logic                 err_o
);

  localparam int unsigned ExW    = RegAddrW + DataWidth;
  localparam int unsigned LqCntW = $clog2(MaxLoads + 1);
  localparam int unsigned ExCntW = $clog2(ExBufDepth + 1);

  logic [4:0] ex_waddr, load_waddr, raddr_a, raddr_b;

  assign ex_waddr   = rf_addr_norm(ex_waddr_i, RV32E);
  assign load_waddr = rf_addr_norm(load_waddr_i, RV32E);
  assign raddr_a    = rf_addr_norm(raddr_a_i, RV32E);
  assign raddr_b    = rf_addr_norm(raddr_b_i, RV32E);

  // Load tag queue
  logic [4:0]                   lq_head;
  logic [LqCntW-1:0]            lq_count;
  logic [MaxLoads-1:0]          lq_valid;
  logic [MaxLoads*RegAddrW-1:0] lq_tags;
  logic                         lq_empty, lq_full;

  ibex_rf_wb_fifo #(
    .Width   (RegAddrW),
    .TagWidth(RegAddrW),
    .Depth   (MaxLoads)
  ) u_load_q (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (load_issue_i),
    .wdata_i(load_waddr),
    .pop_i  (load_rvalid_i),
    .rdata_o(lq_head),
    .count_o(lq_count),
    .valid_o(lq_valid),
    .tags_o (lq_tags)
  );

  assign lq_empty = (lq_count == '0);
  assign lq_full  = (lq_count == LqCntW'(MaxLoads));

  // EX result buffer, entries are {waddr, wdata}
  logic [ExW-1:0]                 exf_head;
  logic [ExCntW-1:0]              exf_count;
  logic [ExBufDepth-1:0]          exf_valid;
  logic [ExBufDepth*RegAddrW-1:0] exf_tags;
  logic                           exf_empty, exf_push, exf_pop;

  ibex_rf_wb_fifo #(
    .Width   (ExW),
    .TagWidth(RegAddrW),
    .Depth   (ExBufDepth)
  ) u_ex_buf (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (exf_push),
    .wdata_i({ex_waddr, ex_wdata_i}),
    .pop_i  (exf_pop),
    .rdata_o(exf_head),
    .count_o(exf_count),
    .valid_o(exf_valid),
    .tags_o (exf_tags)
  );

  assign exf_empty = (exf_count == '0);

  logic                 ex_accept, load_win;
  logic                 rf_we_q, rf_we_d;
  logic [4:0]           rf_waddr_q, rf_waddr_d;
  logic [DataWidth-1:0] rf_wdata_q, rf_wdata_d;
  logic                 err_q, err_d;
  logic                 has_wr;
  logic [31:0]          pending;

  // Ready depends only on buffer occupancy so EX never sees a comb loop.
  assign ex_ready_o = (exf_count != ExCntW'(ExBufDepth));
  assign ex_accept  = ex_valid_i && ex_ready_o;
  assign load_win   = load_rvalid_i && !lq_empty;

  // Strict-priority pick of this cycle's write: load, buffered EX, bypassed EX.
  always_comb begin
    exf_push   = 1'b0;
    exf_pop    = 1'b0;
    has_wr     = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (load_win) begin
      has_wr     = 1'b1;
      rf_waddr_d = lq_head;
      rf_wdata_d = load_rdata_i;
      exf_push   = ex_accept;
    end else if (!exf_empty) begin
      has_wr     = 1'b1;
      exf_pop    = 1'b1;
      rf_waddr_d = exf_head[ExW-1 -: RegAddrW];
      rf_wdata_d = exf_head[DataWidth-1:0];
      exf_push   = ex_accept;
    end else if (ex_accept) begin
      has_wr     = 1'b1;
      rf_waddr_d = ex_waddr;
      rf_wdata_d = ex_wdata_i;
    end
    rf_we_d = has_wr && (rf_waddr_d != '0);
  end

  // Sticky error: response with no tag, or issue into a full queue without a pop.
  assign err_d = err_q
               | (load_rvalid_i && lq_empty)
               | (load_issue_i && lq_full && !load_rvalid_i);

  // Output write register and error flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      err_q      <= 1'b0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      err_q      <= err_d;
    end
  end

  // Bitmap of registers with a write still in flight; x0 is never pending.
  always_comb begin
    pending = '0;
    for (int i = 0; i < MaxLoads; i++) begin
      if (lq_valid[i]) pending[lq_tags[RegAddrW*i +: RegAddrW]] = 1'b1;
    end
    for (int i = 0; i < ExBufDepth; i++) begin
      if (exf_valid[i]) pending[exf_tags[RegAddrW*i +: RegAddrW]] = 1'b1;
    end
    if (rf_we_q) pending[rf_waddr_q] = 1'b1;
    pending[0] = 1'b0;
  end

  assign hazard_a_o   = pending[raddr_a];
  assign hazard_b_o   = pending[raddr_b];
  assign waw_hazard_o = pending[load_waddr] | pending[ex_waddr];

  assign rf_we_o      = rf_we_q;
  assign rf_waddr_o   = rf_waddr_q;
  assign rf_wdata_o   = rf_wdata_q;
  assign loads_full_o = lq_full;
  assign err_o        = err_q;

endmodule

// File: tb/tb_ibex_rf_write_arbiter.sv
// Bench for the writeback arbiter: directed cycle table, corner sequences,
// and a randomized run against a queue-based reference model.
module tb_ibex_rf_write_arbiter;

  localparam int EXD = 2;
  localparam int ML  = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_ready;
  logic [4:0]  ex_waddr;
  logic [31:0] ex_wdata;
  logic        load_issue, load_rvalid;
  logic [4:0]  load_waddr;
  logic [31:0] load_rdata;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        rf_we;
  logic [4:0]  raddr_a, raddr_b;
  logic        haz_a, haz_b, waw, loads_full, err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ibex_rf_write_arbiter #(
    .DataWidth (32),
    .RV32E     (1'b0),
    .ExBufDepth(EXD),
    .MaxLoads  (ML)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .ex_valid_i   (ex_valid),
    .ex_ready_o   (ex_ready),
    .ex_waddr_i   (ex_waddr),
    .ex_wdata_i   (ex_wdata),
    .load_issue_i (load_issue),
    .load_waddr_i (load_waddr),
    .load_rvalid_i(load_rvalid),
    .load_rdata_i (load_rdata),
    .rf_waddr_o   (rf_waddr),
    .rf_wdata_o   (rf_wdata),
    .rf_we_o      (rf_we),
    .raddr_a_i    (raddr_a),
    .raddr_b_i    (raddr_b),
    .hazard_a_o   (haz_a),
    .hazard_b_o   (haz_b),
    .waw_hazard_o (waw),
    .loads_full_o (loads_full),
    .err_o        (err)
  );

  typedef struct {
    logic        ev;
    logic [4:0]  ewa;
    logic [31:0] ewd;
    logic        li;
    logic [4:0]  lwa;
    logic        rv;
    logic [31:0] rd;
    logic [4:0]  ra;
    logic        x_rdy;
    logic        x_haz;
    logic        x_we;
    logic [4:0]  x_wa;
    logic [31:0] x_wd;
  } vec_t;

  vec_t vecs[12];

  // reference model state
  logic [4:0]  m_lq[$];
  logic [36:0] m_ex[$];
  bit          m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  bit          m_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ev, input logic [4:0] ewa, input logic [31:0] ewd,
                              input logic li, input logic [4:0] lwa,
                              input logic rv, input logic [31:0] rd, input logic [4:0] ra,
                              input logic x_rdy, input logic x_haz,
                              input logic x_we, input logic [4:0] x_wa, input logic [31:0] x_wd);
    vec_t v;
    v.ev = ev; v.ewa = ewa; v.ewd = ewd; v.li = li; v.lwa = lwa; v.rv = rv; v.rd = rd;
    v.ra = ra; v.x_rdy = x_rdy; v.x_haz = x_haz; v.x_we = x_we; v.x_wa = x_wa; v.x_wd = x_wd;
    return v;
  endfunction

  task automatic idle();
    ex_valid = 0; ex_waddr = 0; ex_wdata = 0;
    load_issue = 0; load_waddr = 0; load_rvalid = 0; load_rdata = 0;
    raddr_a = 0; raddr_b = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    step();
    rst_n = 1;
  endtask

  function automatic bit m_pend(input logic [4:0] a);
    if (a == 5'd0) return 0;
    if (m_we && m_addr == a) return 1;
    foreach (m_lq[i]) if (m_lq[i] == a) return 1;
    foreach (m_ex[i]) if (m_ex[i][36:32] == a) return 1;
    return 0;
  endfunction

  task automatic model_step();
    logic [36:0] e;
    bit acc, lwin;
    acc  = ex_valid && (m_ex.size() < EXD);
    lwin = load_rvalid && (m_lq.size() != 0);
    if (load_rvalid && m_lq.size() == 0) m_err = 1;
    if (load_issue && m_lq.size() == ML && !load_rvalid) m_err = 1;
    if (lwin) begin
      m_addr = m_lq.pop_front();
      m_data = load_rdata;
      m_we   = (m_addr != 0);
      if (acc) m_ex.push_back({ex_waddr, ex_wdata});
    end else if (m_ex.size() != 0) begin
      e      = m_ex.pop_front();
      m_addr = e[36:32];
      m_data = e[31:0];
      m_we   = (m_addr != 0);
      if (acc) m_ex.push_back({ex_waddr, ex_wdata});
    end else if (acc) begin
      m_addr = ex_waddr;
      m_data = ex_wdata;
      m_we   = (m_addr != 0);
    end else begin
      m_we = 0;
    end
    if (load_issue && m_lq.size() < ML) m_lq.push_back(load_waddr);
  endtask

  initial begin
    // ev ewa ewd      li lwa rv rd     ra  | rdy haz we wa wd
    vecs[0]  = mk(1, 5, 32'h1234, 0, 0, 0, 0,     5, 1, 0, 1, 5, 32'h1234);
    vecs[1]  = mk(0, 0, 0,        0, 0, 0, 0,     5, 1, 1, 0, 0, 0);
    vecs[2]  = mk(0, 0, 0,        0, 0, 0, 0,     5, 1, 0, 0, 0, 0);
    vecs[3]  = mk(0, 0, 0,        1, 7, 0, 0,     7, 1, 0, 0, 0, 0);
    vecs[4]  = mk(0, 0, 0,        1, 6, 0, 0,     7, 1, 1, 0, 0, 0);
    vecs[5]  = mk(1, 1, 32'h11,   0, 0, 1, 32'h77, 6, 1, 1, 1, 7, 32'h77);
    vecs[6]  = mk(1, 2, 32'h22,   0, 0, 1, 32'h66, 1, 1, 1, 1, 6, 32'h66);
    vecs[7]  = mk(1, 3, 32'h33,   0, 0, 0, 0,     2, 0, 1, 1, 1, 32'h11);
    vecs[8]  = mk(1, 3, 32'h33,   0, 0, 0, 0,     3, 1, 0, 1, 2, 32'h22);
    vecs[9]  = mk(0, 0, 0,        0, 0, 0, 0,     3, 1, 1, 1, 3, 32'h33);
    vecs[10] = mk(0, 0, 0,        0, 0, 0, 0,     3, 1, 1, 0, 0, 0);
    vecs[11] = mk(0, 0, 0,        0, 0, 0, 0,     3, 1, 0, 0, 0, 0);

    idle();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst we", rf_we, 0);
    chk("rst waddr", rf_waddr, 0);
    chk("rst wdata", rf_wdata, 0);
    chk("rst ready", ex_ready, 1);
    chk("rst loads_full", loads_full, 0);
    chk("rst err", err, 0);
    chk("rst haz", {haz_a, haz_b, waw}, 0);
    rst_n = 1;

    // directed cycle table: EX bypass, then loads starving EX until the buffer fills
    for (int i = 0; i < 12; i++) begin
      ex_valid = vecs[i].ev; ex_waddr = vecs[i].ewa; ex_wdata = vecs[i].ewd;
      load_issue = vecs[i].li; load_waddr = vecs[i].lwa;
      load_rvalid = vecs[i].rv; load_rdata = vecs[i].rd;
      raddr_a = vecs[i].ra; raddr_b = 0;
      @(negedge clk);
      chk($sformatf("vec%0d ready", i), ex_ready, vecs[i].x_rdy);
      chk($sformatf("vec%0d haz_a", i), haz_a, vecs[i].x_haz);
      step();
      chk($sformatf("vec%0d we", i), rf_we, vecs[i].x_we);
      if (vecs[i].x_we) begin
        chk($sformatf("vec%0d waddr", i), rf_waddr, vecs[i].x_wa);
        chk($sformatf("vec%0d wdata", i), rf_wdata, vecs[i].x_wd);
      end
    end
    chk("table err", err, 0);

    // load queue full and issue protocol errors
    do_reset();
    load_issue = 1; load_waddr = 9;
    @(negedge clk); chk("lq one full", loads_full, 0);
    step();
    load_waddr = 10;
    step();
    idle(); raddr_a = 10;
    @(negedge clk);
    chk("lq two full", loads_full, 1);
    chk("lq haz10", haz_a, 1);
    step();
    load_issue = 1; load_waddr = 11; load_rvalid = 1; load_rdata = 32'h99;
    step();
    chk("lq pop+push we", rf_we, 1);
    chk("lq pop+push waddr", rf_waddr, 9);
    chk("lq pop+push wdata", rf_wdata, 32'h99);
    chk("lq pop+push err", err, 0);
    idle();
    @(negedge clk); chk("lq still full", loads_full, 1);
    step();
    load_issue = 1; load_waddr = 12;
    step();
    chk("lq overflow err", err, 1);
    idle(); load_rvalid = 1; load_rdata = 32'hA0;
    step();
    chk("lq drain0 waddr", rf_waddr, 10);
    load_rdata = 32'hB0;
    step();
    chk("lq drain1 waddr", rf_waddr, 11);
    chk("lq drain1 wdata", rf_wdata, 32'hB0);
    idle(); raddr_a = 12;
    @(negedge clk);
    chk("lq dropped push empty", loads_full, 0);
    chk("lq dropped push haz", haz_a, 0);
    step();

    // response with no outstanding load
    do_reset();
    load_rvalid = 1; load_rdata = 32'hDEAD;
    step();
    chk("empty rv we", rf_we, 0);
    chk("empty rv err", err, 1);
    idle();
    repeat (3) step();
    chk("empty rv err sticky", err, 1);
    chk("empty rv no write", rf_we, 0);

    // writes to x0
    do_reset();
    ex_valid = 1; ex_waddr = 0; ex_wdata = 32'hFFFF_FFFF; raddr_a = 0; raddr_b = 0;
    @(negedge clk);
    chk("x0 haz_a pre", haz_a, 0);
    step();
    chk("x0 ex we", rf_we, 0);
    idle(); load_issue = 1; load_waddr = 0;
    @(negedge clk);
    chk("x0 haz after", {haz_a, haz_b}, 0);
    step();
    idle(); load_waddr = 0;
    @(negedge clk); chk("x0 waw", waw, 0);
    load_rvalid = 1; load_rdata = 32'h55;
    step();
    chk("x0 load we", rf_we, 0);
    chk("x0 err", err, 0);

    // reset with both buffers occupied
    do_reset();
    load_issue = 1; load_waddr = 7; step();
    load_waddr = 6; step();
    load_waddr = 5; load_rvalid = 1; load_rdata = 32'h70; ex_valid = 1; ex_waddr = 1; ex_wdata = 32'h1;
    step();
    load_waddr = 4; load_rdata = 32'h60; ex_waddr = 2; ex_wdata = 32'h2;
    step();
    idle(); raddr_a = 4; raddr_b = 1; load_waddr = 5;
    @(negedge clk);
    chk("occ ready", ex_ready, 0);
    chk("occ loads_full", loads_full, 1);
    chk("occ haz", {haz_a, haz_b, waw}, 3'b111);
    #2 rst_n = 0;
    #1;
    chk("arst we", rf_we, 0);
    chk("arst waddr", rf_waddr, 0);
    chk("arst wdata", rf_wdata, 0);
    chk("arst ready", ex_ready, 1);
    chk("arst loads_full", loads_full, 0);
    chk("arst haz", {haz_a, haz_b, waw}, 0);
    chk("arst err", err, 0);
    step();
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("post rst no write %0d", i), rf_we, 0);
    end
    @(negedge clk); chk("post rst haz", {haz_a, haz_b, waw}, 0);
    step();

    // randomized run against the reference model
    do_reset();
    m_lq.delete(); m_ex.delete();
    m_we = 0; m_addr = 0; m_data = 0; m_err = 0;
    for (int c = 0; c < 1500; c++) begin
      ex_valid    = 1'($urandom_range(0, 1));
      ex_waddr    = 5'($urandom_range(0, 7));
      ex_wdata    = $urandom;
      load_waddr  = 5'($urandom_range(0, 7));
      load_issue  = ($urandom_range(0, 99) < 30) &&
                    ((m_lq.size() < ML) || ($urandom_range(0, 99) < 5));
      load_rvalid = (m_lq.size() > 0) ? ($urandom_range(0, 99) < 45)
                                      : ($urandom_range(0, 299) == 0);
      load_rdata  = $urandom;
      raddr_a     = 5'($urandom_range(0, 7));
      raddr_b     = 5'($urandom_range(0, 7));
      @(negedge clk);
      chk("rnd ready", ex_ready, (m_ex.size() < EXD));
      chk("rnd loads_full", loads_full, (m_lq.size() == ML));
      chk("rnd haz_a", haz_a, m_pend(raddr_a));
      chk("rnd haz_b", haz_b, m_pend(raddr_b));
      chk("rnd waw", waw, m_pend(load_waddr) | m_pend(ex_waddr));
      model_step();
      step();
      chk("rnd we", rf_we, m_we);
      chk("rnd err", err, m_err);
      if (m_we) begin
        chk("rnd waddr", rf_waddr, m_addr);
        chk("rnd wdata", rf_wdata, m_data);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
